// File: rtl/instr_issue_pkg.sv
// Shared types for the instruction issue stage: FSM state encoding and instruction width.
package instr_issue_pkg;

   localparam int INSTR_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } issue_state_t;

endpackage

// File: rtl/instr_issue_fifo.sv
// issue_fifo: instruction queue with power-of-two depth, count, full/empty and a sticky drop flag.
module issue_fifo
   import instr_issue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [INSTR_W-1:0]       push_data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [INSTR_W-1:0]       head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               overflow_q;
   logic               full, empty, wr_en, rd_en;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
   assign wr_en = push_i && !full && !flush_i;
   assign rd_en = pop_i && !empty;

   // NOTE: storage is deliberately left out of reset; only pointers and count decide validity.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_i && full && !flush_i) overflow_q <= 1'b1;
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
               2'b10:   count_q <= count_q + CNT_W'(1);
               2'b01:   count_q <= count_q - CNT_W'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   assign head_o     = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign full_o     = full;
   assign empty_o    = empty;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/instr_issue.sv
// instr_issue: queues instructions and sequences load/start/wait handshakes into the cpu block.
// Optional watchdog compiled in with INSTR_ISSUE_TIMEOUT_EN.
module instr_issue
   import instr_issue_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [INSTR_W-1:0]       push_data,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [INSTR_W-1:0]       cpu_in,
   output logic                     cpu_load,
   output logic                     cpu_s,
   input  logic                     cpu_w,
   output logic                     busy,
   output logic [15:0]              issued,
   output logic                     overflow,
   output logic                     timeout_err
);

   issue_state_t       state_q;
   logic [INSTR_W-1:0] cpu_in_q, head;
   logic               cpu_load_q, cpu_s_q;
   logic [15:0]        issued_q;
   logic               pop, wd_expired;

   issue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .flush_i     (flush),
      .head_o      (head),
      .count_o     (count),
      .full_o      (full),
      .empty_o     (empty),
      .overflow_o  (overflow)
   );

   assign pop = (state_q == IDLE) && !empty && cpu_w;

`ifdef INSTR_ISSUE_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_q;
   logic            timeout_err_q;

   // Expires on the edge that completes TIMEOUT cycles of waiting since WAIT_BUSY entry.
   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_q          <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (state_q == START) wd_q <= '0;
         else if (state_q == WAIT_BUSY || state_q == WAIT_DONE) wd_q <= wd_q + WD_W'(1);
         if (wd_expired && (state_q == WAIT_BUSY || (state_q == WAIT_DONE && !cpu_w)))
            timeout_err_q <= 1'b1;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign wd_expired  = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cpu_in_q   <= '0;
         cpu_load_q <= 1'b0;
         cpu_s_q    <= 1'b0;
         issued_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q    <= LOAD;
                  cpu_in_q   <= head;
                  cpu_load_q <= 1'b1;
               end
            end
            LOAD: begin
               state_q    <= START;
               cpu_load_q <= 1'b0;
               cpu_s_q    <= 1'b1;
            end
            START: begin
               state_q <= WAIT_BUSY;
               cpu_s_q <= 1'b0;
            end
            WAIT_BUSY: begin
               if (wd_expired)  state_q <= IDLE;
               else if (!cpu_w) state_q <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (cpu_w) begin
                  state_q  <= IDLE;
                  issued_q <= issued_q + 16'd1;
               end else if (wd_expired) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_in   = cpu_in_q;
   assign cpu_load = cpu_load_q;
   assign cpu_s    = cpu_s_q;
   assign busy     = (state_q != IDLE);
   assign issued   = issued_q;

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: queue-based reference model plus directed and random phases.
`timescale 1ns/1ps
module tb_instr_issue;
   import instr_issue_pkg::*;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 64;
   localparam int CNT_W   = $clog2(DEPTH) + 1;
`ifdef INSTR_ISSUE_TIMEOUT_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic             clk = 1'b0, reset = 1'b1, push = 1'b0, flush = 1'b0, cpu_w = 1'b1;
   logic [15:0]      push_data = '0;
   logic             full, empty, cpu_load, cpu_s, busy, overflow, timeout_err;
   logic [CNT_W-1:0] count;
   logic [15:0]      cpu_in, issued;

   instr_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .push(push), .push_data(push_data), .flush(flush),
      .full(full), .empty(empty), .count(count), .cpu_in(cpu_in), .cpu_load(cpu_load),
      .cpu_s(cpu_s), .cpu_w(cpu_w), .busy(busy), .issued(issued), .overflow(overflow),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of pending words plus the phase of the instruction in flight
   // (0 idle, 1 load, 2 start, 3 waiting for w low, 4 waiting for w high).
   logic [15:0] mq[$];
   int          ph = 0, m_wait = 0;
   logic [15:0] m_in = '0, m_issued = '0;
   logic        m_ovf = 1'b0, m_terr = 1'b0;
   bit          m_full, m_take, m_exp;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         ph = 0; m_wait = 0; m_in = '0; m_issued = '0; m_ovf = 1'b0; m_terr = 1'b0;
      end else begin
         m_full = (mq.size() == DEPTH);
         m_take = (ph == 0) && (mq.size() != 0) && cpu_w;
         m_exp  = WD_ON && (ph == 3 || ph == 4) && (m_wait + 1 == TIMEOUT);
         if (m_take) m_in = mq[0];
         if (flush) mq.delete();
         else begin
            if (m_take) void'(mq.pop_front());
            if (push) begin
               if (m_full) m_ovf = 1'b1;
               else        mq.push_back(push_data);
            end
         end
         case (ph)
            0: if (m_take) ph = 1;
            1: ph = 2;
            2: begin ph = 3; m_wait = 0; end
            3: begin
               if (m_exp) begin ph = 0; m_terr = 1'b1; end
               else if (!cpu_w) ph = 4;
               m_wait++;
            end
            4: begin
               if (cpu_w) begin ph = 0; m_issued = m_issued + 16'd1; end
               else if (m_exp) begin ph = 0; m_terr = 1'b1; end
               m_wait++;
            end
            default: ph = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      check("m_count", count, mq.size());
      check("m_empty", empty, mq.size() == 0);
      check("m_full", full, mq.size() == DEPTH);
      check("m_cpu_in", cpu_in, m_in);
      check("m_cpu_load", cpu_load, ph == 1);
      check("m_cpu_s", cpu_s, ph == 2);
      check("m_busy", busy, ph != 0);
      check("m_issued", issued, m_issued);
      check("m_overflow", overflow, m_ovf);
      check("m_timeout_err", timeout_err, m_terr);
   end

   // CPU responder: after s, drop w after d cycles, raise it r cycles later.
   bit cpu_auto = 1'b0;
   int d_lo = 1, d_hi = 1, r_lo = 3, r_hi = 3, drop_cnt = 0, rise_cnt = 0;

   initial forever begin
      @(posedge clk); #1;
      if (cpu_auto) begin
         if (cpu_s) drop_cnt = $urandom_range(d_hi, d_lo);
         else if (drop_cnt > 0) begin
            drop_cnt--;
            if (drop_cnt == 0) begin cpu_w = 1'b0; rise_cnt = $urandom_range(r_hi, r_lo); end
         end else if (rise_cnt > 0) begin
            rise_cnt--;
            if (rise_cnt == 0) cpu_w = 1'b1;
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_count"}, count, 0);
      check({tag, "_empty"}, empty, 1);
      check({tag, "_full"}, full, 0);
      check({tag, "_cpu_in"}, cpu_in, 0);
      check({tag, "_load"}, cpu_load, 0);
      check({tag, "_s"}, cpu_s, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_issued"}, issued, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((busy || !empty) && n < budget) begin step(); n++; end
      check({tag, "_idle_bound"}, n < budget, 1);
   endtask

   task automatic wait_s(input string tag);
      int n = 0;
      while (!cpu_s && n < 20) begin step(); n++; end
      check({tag, "_s_bound"}, n < 20, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   logic [15:0] order [8];
   int          got, n;

   initial begin
      #2 reset = 1'b0;
      #6 check_reset_vals("rst");
      #5 reset = 1'b1;
      step();

      // Single issue: load two edges after push, start next cycle, one completion.
      cpu_auto = 1'b1;
      push = 1'b1; push_data = 16'hD004; step(); push = 1'b0;
      check("si_count", count, 1);
      check("si_load_early", cpu_load, 0);
      step();
      check("si_load", cpu_load, 1);
      check("si_cpu_in", cpu_in, 16'hD004);
      check("si_s_early", cpu_s, 0);
      step();
      check("si_s", cpu_s, 1);
      check("si_load_off", cpu_load, 0);
      wait_idle("si", 40);
      check("si_issued", issued, 1);
      check("si_busy", busy, 0);

      // Push and pop in one cycle at count 1.
      cpu_auto = 1'b0; cpu_w = 1'b0;
      push = 1'b1; push_data = 16'h0A0A; step(); push = 1'b0;
      check("pp_pre_count", count, 1);
      cpu_w = 1'b1; push = 1'b1; push_data = 16'h0B0B; step(); push = 1'b0;
      check("pp_count", count, 1);
      check("pp_load", cpu_load, 1);
      check("pp_cpu_in", cpu_in, 16'h0A0A);
      cpu_auto = 1'b1;
      wait_idle("pp", 60);
      check("pp_issued", issued, 3);

      // Flush with push at count 0.
      push = 1'b1; flush = 1'b1; push_data = 16'hFFFF; step(); push = 1'b0; flush = 1'b0;
      check("fp_count", count, 0);
      check("fp_overflow", overflow, 0);

      // Flush while an instruction waits for completion.
      cpu_auto = 1'b0; cpu_w = 1'b1;
      push = 1'b1; push_data = 16'h1111; step(); push = 1'b0;
      wait_s("fm");
      cpu_w = 1'b0; step(2);
      check("fm_busy_wait", busy, 1);
      for (int i = 0; i < 3; i++) begin
         push = 1'b1; push_data = 16'h2000 + 16'(i); step();
      end
      push = 1'b0;
      check("fm_queued", count, 3);
      flush = 1'b1; step(); flush = 1'b0;
      check("fm_count", count, 0);
      check("fm_empty", empty, 1);
      check("fm_busy", busy, 1);
      check("fm_cpu_in", cpu_in, 16'h1111);
      cpu_w = 1'b1; step(3);
      check("fm_issued", issued, 4);
      check("fm_idle", busy, 0);

      // Overflow: nine pushes with the CPU busy, then issue order.
      cpu_w = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         push = 1'b1; push_data = 16'(i); step();
      end
      push = 1'b0;
      check("ov_count", count, 8);
      check("ov_full", full, 1);
      check("ov_flag", overflow, 1);
      cpu_auto = 1'b1; cpu_w = 1'b1;
      got = 0; n = 0;
      while ((got < 8 || busy) && n < 300) begin
         step(); n++;
         if (cpu_load && got < 8) begin order[got] = cpu_in; got++; end
      end
      check("ov_bound", n < 300, 1);
      for (int i = 0; i < 8; i++) check($sformatf("ov_order%0d", i), order[i], i + 1);
      check("ov_issued", issued, 12);

      // Watchdog / indefinite wait.
      cpu_auto = 1'b0; cpu_w = 1'b1;
      push = 1'b1; push_data = 16'hBEEF; step(); push = 1'b0;
      wait_s("wd");
      cpu_w = 1'b0;
`ifdef INSTR_ISSUE_TIMEOUT_EN
      step(64);
      check("wd_not_yet", timeout_err, 0);
      check("wd_busy_before", busy, 1);
      step();
      check("wd_flag", timeout_err, 1);
      check("wd_idle", busy, 0);
      check("wd_issued", issued, 12);
      cpu_w = 1'b1; step();
`else
      step(100);
      check("wd_busy_held", busy, 1);
      check("wd_flag_off", timeout_err, 0);
      cpu_w = 1'b1; step(3);
      check("wd_done", busy, 0);
      check("wd_issued", issued, 13);
`endif

      // Random traffic with one asynchronous mid-cycle reset.
      d_lo = 1; d_hi = 3; r_lo = 1; r_hi = 4; cpu_auto = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         if (c == 700) begin
            push = 1'b0; flush = 1'b0;
            #3 reset = 1'b0;
            cpu_auto = 1'b0; drop_cnt = 0; rise_cnt = 0; cpu_w = 1'b1;
            #1 check_reset_vals("mid_rst");
            step(2);
            #2 reset = 1'b1;
            cpu_auto = 1'b1;
            step();
         end
         push      = ($urandom_range(99) < 45);
         push_data = 16'($urandom);
         flush     = ($urandom_range(99) < 3);
         step();
      end
      push = 1'b0; flush = 1'b0;
      wait_idle("rnd", 400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_issue.md
# instr_issue

Instruction issue stage that sits directly upstream of the `cpu` block. It buffers 16-bit instructions pushed by a host or loader in a small FIFO and sequences each one into the CPU. For each instruction it drives `load` to latch the instruction register, pulses `s` to start execution, then waits on `w` until the CPU returns to its wait state. It also counts completed instructions and flags overflow and hangs.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `TIMEOUT`, 64: maximum cycles spent waiting on the CPU per instruction (only used when the watchdog is compiled in).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `push` in 1: enqueue `push_data` this cycle.
- `push_data` in 16: instruction word.
- `flush` in 1: discard all queued (not yet issued) instructions.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out $clog2(DEPTH)+1: number of queued entries.
- `cpu_in` out 16: to cpu `in`.
- `cpu_load` out 1: to cpu `load`.
- `cpu_s` out 1: to cpu `s`.
- `cpu_w` in 1: from cpu `w`; 1 means the CPU is idle and waiting.
- `busy` out 1: state != IDLE.
- `issued` out 16: completed-instruction counter; wraps 0xFFFF to 0x0000.
- `overflow` out 1: sticky; set when a push is dropped.
- `timeout_err` out 1: sticky watchdog flag; constant 0 when the watchdog is compiled out.

## Operation
- Moore FSM with states IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
- **IDLE:** if `!empty && cpu_w`, go to LOAD. On that edge:
  - capture the FIFO head into the `cpu_in` register;
  - pop the head.
- **LOAD:** `cpu_load`=1 for exactly one cycle; next state START.
- **START:** `cpu_s`=1 for exactly one cycle; next state WAIT_BUSY.
- **WAIT_BUSY:** wait for `cpu_w`==0, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `cpu_w`==1, then go to IDLE and increment `issued` by 1.
- `cpu_in` holds its captured value from LOAD until the next IDLE→LOAD transition; it is never changed by push or flush.
- **Push rules:**
  - A push is accepted when `!full`, judged on the registered count.
  - A push while full is dropped and sets `overflow`, even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: count is unchanged, and both pointers advance modulo DEPTH.
- **Flush:**
  - Clears both pointers and count on the next edge.
  - Flush wins over a same-cycle push; that push is discarded and does not set `overflow`.
  - Flush wins over a same-cycle pop, but the head is still captured into `cpu_in` and issued.
  - The in-flight instruction always completes.
- Sticky flags clear only on reset.

## Timing
- **Reset** (asynchronous, takes effect with no clock edge):
  - state IDLE;
  - `cpu_in`=0, `cpu_load`=0, `cpu_s`=0;
  - `count`=0, `empty`=1, `full`=0;
  - `busy`=0, `issued`=0, `overflow`=0, `timeout_err`=0.
- **Push to load latency:** push accepted at edge k → `empty`=0 after k → LOAD entered at edge k+1 (if `cpu_w`=1) → `cpu_load` high during cycle k+1..k+2.
- `cpu_s` is high in the cycle immediately after `cpu_load`; the two are never high together.
- **Minimum issue period:** 5 cycles, when the CPU drops `w` one cycle after `s` and raises it one cycle later.
- Back-to-back instructions: IDLE→LOAD occurs on the edge after WAIT_DONE→IDLE.
- A reset asserted mid-operation abandons the instruction without incrementing `issued`.

## Configuration
- **`INSTR_ISSUE_TIMEOUT_EN` defined:**
  - A cycle counter clears on entry to WAIT_BUSY and runs through WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT, set `timeout_err` and go to IDLE without incrementing `issued`.
- **Not defined:** no counter is built, the FSM waits indefinitely, and `timeout_err` is tied 0.

## Structure
- Package `instr_issue_pkg` holds:
  - the `issue_state_t` enum for the five states;
  - the `INSTR_W`=16 constant.
- One sub-module, `issue_fifo`, containing storage, pointers, count, full/empty and the overflow detect.
- The FSM, `issued` counter and watchdog live in the top level.

## Test plan
- **Reset:** assert reset asynchronously mid-cycle → all outputs at their reset values immediately, with no edge needed.
- **Single issue:**
  - Stimulus: push 0xD004 with a CPU model holding `w`=1, then dropping `w` one cycle after `s` and raising it 3 cycles later.
  - Required: `cpu_load`=1 for one cycle, 2 edges after the push, with `cpu_in`=0xD004; `cpu_s` follows next cycle; `issued`=1; `busy`=0 afterwards.
- **Overflow:** `cpu_w`=0, push 9 words 0x0001..0x0009 → `count`=8, `full`=1, `overflow`=1; after releasing `w`, issue order is 0x0001..0x0008.
- **Flush mid-flight:** 3 queued while in WAIT_DONE; assert `flush` → `count`=0, `empty`=1; the current instruction completes and `issued` increments by exactly 1.
- **Watchdog:** with `INSTR_ISSUE_TIMEOUT_EN` and TIMEOUT=64, hold `w`=0 after `s` → `timeout_err`=1 64 cycles after WAIT_BUSY entry, state IDLE; without the macro, `busy` stays 1.
- **Simultaneous events:** push and pop in the same cycle at count=1 → `count` stays 1; flush+push at count=0 → `count`=0, `overflow`=0.
